// File: rtl/dram_chip_cmd.sv
`default_nettype none
// ============================================================================
// Module   : dram_chip_cmd
// Brief    : Single DRAM device model driven by a shared ACT/RD/WR/PRE/PREA
//            command bus. Tracks per-bank open rows, enforces tRCD/CL/CWL and
//            sequences wrapped BL-beat bursts against internal storage.
// Revision : 1.0 - initial release
// ============================================================================
module dram_chip_cmd #(
  parameter int BGWIDTH      = 2,
  parameter int BAWIDTH      = 2,
  parameter int ADDRWIDTH    = 8,
  parameter int COLWIDTH     = 4,
  parameter int DEVICE_WIDTH = 4,
  parameter int BL           = 8,
  parameter int TRCD         = 3,
  parameter int TCL          = 4,
  parameter int TCWL         = 3
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [2:0]                                             cmd,
  input  logic [BGWIDTH-1:0]                                     bg,
  input  logic [BAWIDTH-1:0]                                     ba,
  input  logic [((ADDRWIDTH > COLWIDTH) ? ADDRWIDTH : COLWIDTH)-1:0] addr,
  input  logic [DEVICE_WIDTH-1:0]                                dqin,
  output logic [DEVICE_WIDTH-1:0]                                dqout,
  output logic                                                   dq_valid,
  output logic                                                   cmd_err,
  output logic [(1 << (BGWIDTH + BAWIDTH))-1:0]                  bank_open,
  output logic                                                   busy
);

  localparam int BANKW   = BGWIDTH + BAWIDTH;
  localparam int NBANKS  = 1 << BANKW;
  localparam int MEMW    = BANKW + ADDRWIDTH + COLWIDTH;
  localparam int LAT_MAX = (TCL > TCWL) ? TCL : TCWL;
  localparam int WAITW   = $clog2(LAT_MAX + 1);
  localparam int RCDW    = $clog2(TRCD + 1);

  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;

  typedef logic [COLWIDTH-1:0] col_t;
  localparam col_t BEAT_MASK = col_t'(BL - 1);
  localparam col_t LAST_BEAT = col_t'(BL - 1);

  typedef enum logic [1:0] {
    BANK_IDLE       = 2'd0,
    BANK_ACTIVATING = 2'd1,
    BANK_ACTIVE     = 2'd2
  } bank_state_t;

  bank_state_t          bank_state [NBANKS];
  logic [RCDW-1:0]      bank_cnt   [NBANKS];
  logic [ADDRWIDTH-1:0] bank_row   [NBANKS];

  logic [DEVICE_WIDTH-1:0] mem [0:(1 << MEMW)-1];

  logic                 burst_rd;
  logic [BANKW-1:0]     burst_bank;
  logic [ADDRWIDTH-1:0] burst_row;
  col_t                 burst_col;
  logic [WAITW-1:0]     wait_cnt;
  col_t                 beat_cnt;

  // Column of beat idx: sequential order wrapping inside the BL-aligned block
  function automatic col_t beat_col(input col_t base, input col_t idx);
    return (base & ~BEAT_MASK) | ((base + idx) & BEAT_MASK);
  endfunction

  logic [BANKW-1:0] cmd_bank;
  bank_state_t      tgt_state;
  logic             is_act, is_rd, is_wr, is_rw, is_pre, is_prea;
  logic             act_ok, rw_ok, pre_ok, prea_ok, illegal;

  assign cmd_bank  = {bg, ba};
  assign tgt_state = bank_state[cmd_bank];
  assign is_act    = (cmd == CMD_ACT);
  assign is_rd     = (cmd == CMD_RD);
  assign is_wr     = (cmd == CMD_WR);
  assign is_rw     = is_rd | is_wr;
  assign is_pre    = (cmd == CMD_PRE);
  assign is_prea   = (cmd == CMD_PREA);

  // A burst owns its bank until the last beat: closing it is refused
  assign act_ok  = is_act && (tgt_state == BANK_IDLE);
  assign rw_ok   = is_rw && (tgt_state == BANK_ACTIVE) && !busy;
  assign pre_ok  = is_pre && !(busy && (burst_bank == cmd_bank));
  assign prea_ok = is_prea && !busy;
  assign illegal = (is_act && !act_ok) | (is_rw && !rw_ok) |
                   (is_pre && !pre_ok) | (is_prea && !prea_ok);

  // Per-bank IDLE/ACTIVATING/ACTIVE tracking; ACTIVE is reached exactly TRCD cycles after ACT
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NBANKS; b++) begin
        bank_state[b] <= BANK_IDLE;
        bank_cnt[b]   <= '0;
        bank_row[b]   <= '0;
      end
    end else begin
      for (int b = 0; b < NBANKS; b++) begin
        case (bank_state[b])
          BANK_IDLE: begin
            if (act_ok && (cmd_bank == BANKW'(b))) begin
              bank_state[b] <= (TRCD == 1) ? BANK_ACTIVE : BANK_ACTIVATING;
              bank_cnt[b]   <= RCDW'(TRCD - 1);
              bank_row[b]   <= addr[ADDRWIDTH-1:0];
            end
          end
          BANK_ACTIVATING: begin
            if (prea_ok || (pre_ok && (cmd_bank == BANKW'(b)))) begin
              bank_state[b] <= BANK_IDLE;
            end else if (bank_cnt[b] <= RCDW'(1)) begin
              bank_state[b] <= BANK_ACTIVE;
              bank_cnt[b]   <= '0;
            end else begin
              bank_cnt[b] <= bank_cnt[b] - RCDW'(1);
            end
          end
          BANK_ACTIVE: begin
            if (prea_ok || (pre_ok && (cmd_bank == BANKW'(b)))) begin
              bank_state[b] <= BANK_IDLE;
            end
          end
          default: bank_state[b] <= BANK_IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NBANKS; g++) begin : g_open
    assign bank_open[g] = (bank_state[g] == BANK_ACTIVE);
  end

  // Burst engine: latency countdown, then BL beats; bank/row/column latched at accept
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      burst_rd   <= 1'b0;
      burst_bank <= '0;
      burst_row  <= '0;
      burst_col  <= '0;
      wait_cnt   <= '0;
      beat_cnt   <= '0;
    end else if (rw_ok) begin
      busy       <= 1'b1;
      burst_rd   <= is_rd;
      burst_bank <= cmd_bank;
      burst_row  <= bank_row[cmd_bank];
      burst_col  <= addr[COLWIDTH-1:0];
      wait_cnt   <= is_rd ? WAITW'(TCL - 1) : WAITW'(TCWL - 1);
      beat_cnt   <= '0;
    end else if (busy) begin
      if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WAITW'(1);
      end else begin
        if (beat_cnt == LAST_BEAT) busy <= 1'b0;
        beat_cnt <= beat_cnt + col_t'(1);
      end
    end
  end

  logic            beat_active;
  logic            wr_en;
  logic [MEMW-1:0] wr_idx;
  logic            rd_first_now, rd_first_later, rd_more, rd_next;
  logic [MEMW-1:0] rd_idx;

  assign beat_active = busy && (wait_cnt == '0);
  assign wr_en       = beat_active && !burst_rd && !reset;
  assign wr_idx      = {burst_bank, burst_row, beat_col(burst_col, beat_cnt)};

  // The read register is loaded one cycle ahead of each beat, so with TCL=1
  // the first beat address comes straight from the accepted command
  assign rd_first_now   = rw_ok && is_rd && (TCL == 1);
  assign rd_first_later = busy && burst_rd && (wait_cnt == WAITW'(1));
  assign rd_more        = beat_active && burst_rd && (beat_cnt != LAST_BEAT);
  assign rd_next        = rd_first_now | rd_first_later | rd_more;

  always_comb begin
    rd_idx = {burst_bank, burst_row, beat_col(burst_col, beat_cnt + col_t'(1))};
    if (rd_first_now)
      rd_idx = {cmd_bank, bank_row[cmd_bank], addr[COLWIDTH-1:0]};
    else if (rd_first_later)
      rd_idx = {burst_bank, burst_row, burst_col};
  end

  // Storage write port, contents intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= dqin;
  end

  // Registered read data; dqout forced to zero outside read beats
  always_ff @(posedge clk) begin
    if (reset) begin
      dqout    <= '0;
      dq_valid <= 1'b0;
    end else if (rd_next) begin
      dqout    <= mem[rd_idx];
      dq_valid <= 1'b1;
    end else begin
      dqout    <= '0;
      dq_valid <= 1'b0;
    end
  end

  // One-cycle error pulse following a rejected command
  always_ff @(posedge clk) begin
    if (reset) cmd_err <= 1'b0;
    else       cmd_err <= illegal;
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_chip_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_chip_cmd
// Brief    : Scoreboard bench for dram_chip_cmd: default build plus a
//            BL=4 / COLWIDTH=3 / TCL=1 build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_chip_cmd;

  localparam int TCL1 = 4;
  localparam int TCWL = 3;
  localparam int TCL2 = 1;

  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, PREA = 3'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] dqin = 4'h0;

  logic [2:0] cmd1 = NOP, cmd2 = NOP;
  logic [1:0] bg1 = 0, ba1 = 0, bg2 = 0, ba2 = 0;
  logic [7:0] addr1 = 0, addr2 = 0;
  logic [3:0] dqout1, dqout2;
  logic dq_valid1, dq_valid2, cmd_err1, cmd_err2, busy1, busy2;
  logic [15:0] bank_open1, bank_open2;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    bit         care;
    logic [3:0] data;
  } beat_t;

  beat_t rq1[$], rq2[$];
  int    eq1[$], eq2[$];
  logic [3:0] wsched[int];

  dram_chip_cmd u_dut1 (
    .clk(clk), .reset(reset), .cmd(cmd1), .bg(bg1), .ba(ba1), .addr(addr1),
    .dqin(dqin), .dqout(dqout1), .dq_valid(dq_valid1), .cmd_err(cmd_err1),
    .bank_open(bank_open1), .busy(busy1)
  );

  dram_chip_cmd #(.COLWIDTH(3), .BL(4), .TCL(TCL2)) u_dut2 (
    .clk(clk), .reset(reset), .cmd(cmd2), .bg(bg2), .ba(ba2), .addr(addr2),
    .dqin(dqin), .dqout(dqout2), .dq_valid(dq_valid2), .cmd_err(cmd_err2),
    .bank_open(bank_open2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write data: scheduled beats on their cycles, random junk elsewhere
  always @(posedge clk) begin
    #1;
    if (wsched.exists(cyc)) dqin = wsched[cyc];
    else                    dqin = 4'($urandom);
  end

  // Monitor: pops expected beats / error pulses and compares against the DUTs
  always @(negedge clk) begin
    beat_t b;
    while (rq1.size() > 0 && rq1[0].cyc < cyc) begin
      b = rq1.pop_front(); n_checks++; n_fail++;
      $display("FAIL dut1 beat missing: expected at cycle %0d data %h, not observed", b.cyc, b.data);
    end
    while (rq2.size() > 0 && rq2[0].cyc < cyc) begin
      b = rq2.pop_front(); n_checks++; n_fail++;
      $display("FAIL dut2 beat missing: expected at cycle %0d data %h, not observed", b.cyc, b.data);
    end
    if (dq_valid1) begin
      n_checks++;
      if (rq1.size() == 0) begin
        n_fail++; $display("FAIL dut1 unexpected beat at cycle %0d data %h", cyc, dqout1);
      end else begin
        b = rq1.pop_front();
        if (b.cyc != cyc || (b.care && dqout1 !== b.data)) begin
          n_fail++;
          $display("FAIL dut1 beat: got cycle %0d data %h, expected cycle %0d data %h", cyc, dqout1, b.cyc, b.data);
        end
      end
    end else begin
      n_checks++;
      if (dqout1 !== 4'h0) begin n_fail++; $display("FAIL dut1 idle dqout: got %h expected 0", dqout1); end
    end
    if (dq_valid2) begin
      n_checks++;
      if (rq2.size() == 0) begin
        n_fail++; $display("FAIL dut2 unexpected beat at cycle %0d data %h", cyc, dqout2);
      end else begin
        b = rq2.pop_front();
        if (b.cyc != cyc || (b.care && dqout2 !== b.data)) begin
          n_fail++;
          $display("FAIL dut2 beat: got cycle %0d data %h, expected cycle %0d data %h", cyc, dqout2, b.cyc, b.data);
        end
      end
    end
    while (eq1.size() > 0 && eq1[0] < cyc) begin
      n_checks++; n_fail++;
      $display("FAIL dut1 cmd_err missing: expected at cycle %0d", eq1.pop_front());
    end
    while (eq2.size() > 0 && eq2[0] < cyc) begin
      n_checks++; n_fail++;
      $display("FAIL dut2 cmd_err missing: expected at cycle %0d", eq2.pop_front());
    end
    if (cmd_err1) begin
      n_checks++;
      if (eq1.size() > 0 && eq1[0] == cyc) void'(eq1.pop_front());
      else begin n_fail++; $display("FAIL dut1 cmd_err: got pulse at cycle %0d, expected none", cyc); end
    end
    if (cmd_err2) begin
      n_checks++;
      if (eq2.size() > 0 && eq2[0] == cyc) void'(eq2.pop_front());
      else begin n_fail++; $display("FAIL dut2 cmd_err: got pulse at cycle %0d, expected none", cyc); end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a command for the current cycle, then return to NOP one cycle later
  task automatic issue(input int dut, input logic [2:0] c, input int g, input int b, input int a);
    if (dut == 1) begin cmd1 = c; bg1 = 2'(g); ba1 = 2'(b); addr1 = 8'(a); end
    else          begin cmd2 = c; bg2 = 2'(g); ba2 = 2'(b); addr2 = 8'(a); end
    @(posedge clk); #1;
    cmd1 = NOP; cmd2 = NOP;
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  // Expected beats: beat i is nibble i of d counted from the most significant end
  task automatic exp_beats(input int dut, input int t0, input int n, input logic [31:0] d, input bit care);
    beat_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc = t0 + i; e.care = care; e.data = d[31-4*i -: 4];
      if (dut == 1) rq1.push_back(e); else rq2.push_back(e);
    end
  endtask

  task automatic exp_err(input int dut, input int t);
    if (dut == 1) eq1.push_back(t + 1); else eq2.push_back(t + 1);
  endtask

  task automatic sched_wr(input int t0, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) wsched[t0 + i] = d[31-4*i -: 4];
  endtask

  initial begin
    int t, tw, tr, tr2, tw2, tr3, t5;
    repeat (3) @(posedge clk);
    #1;
    check("reset dqout",     32'(dqout1),     32'h0);
    check("reset dq_valid",  32'(dq_valid1),  32'h0);
    check("reset cmd_err",   32'(cmd_err1),   32'h0);
    check("reset bank_open", 32'(bank_open1), 32'h0);
    check("reset busy",      32'(busy1),      32'h0);
    reset = 1'b0;

    // tRCD: early RD rejected, RD at T+3 accepted
    t = cyc;
    issue(1, ACT, 1, 2, 'h15);
    goto(t + 2);
    check("activating bank_open6", 32'(bank_open1[6]), 32'h0);
    exp_err(1, cyc);
    issue(1, RD, 1, 2, 0);
    check("active bank_open6", 32'(bank_open1[6]), 32'h1);
    exp_beats(1, cyc + TCL1, 8, 32'h0, 1'b0);
    issue(1, RD, 1, 2, 0);
    // ACT to another bank mid-burst is legal
    issue(1, ACT, 0, 0, 'h21);

    // Write 1..8 starting at col 5, read back in place and wrapped from col 0
    goto(t + 15);
    tw = cyc;
    sched_wr(tw + TCWL, 8, 32'h12345678);
    issue(1, WR, 0, 0, 5);
    goto(tw + 11);
    tr = cyc;
    exp_beats(1, tr + TCL1, 8, 32'h12345678, 1'b1);
    issue(1, RD, 0, 0, 5);
    goto(tr + 12);
    tr2 = cyc;
    exp_beats(1, tr2 + TCL1, 8, 32'h45678123, 1'b1);
    issue(1, RD, 0, 0, 0);
    goto(tr2 + 2);
    exp_err(1, cyc);
    issue(1, RD, 0, 0, 3);
    goto(tr2 + 4);
    issue(1, ACT, 2, 1, 3);
    exp_err(1, cyc);
    issue(1, PRE, 0, 0, 0);
    issue(1, PRE, 3, 3, 0);
    check("busy mid-burst", 32'(busy1), 32'h1);

    // PREA refused during a write burst, accepted once busy has fallen
    goto(tr2 + 12);
    tw2 = cyc;
    sched_wr(tw2 + TCWL, 8, 32'h9ABCDEF0);
    issue(1, WR, 0, 0, 8);
    goto(tw2 + 2);
    exp_err(1, cyc);
    issue(1, PREA, 0, 0, 0);
    goto(tw2 + 11);
    check("busy after write", 32'(busy1), 32'h0);
    issue(1, PREA, 0, 0, 0);
    check("bank_open after PREA", 32'(bank_open1), 32'h0);
    issue(1, ACT, 0, 0, 'h21);

    // Read from col 0xA (wraps at 0xF back to 0x8), reset during beat index 3
    goto(tw2 + 15);
    tr3 = cyc;
    exp_beats(1, tr3 + TCL1, 4, 32'hBCDE0000, 1'b1);
    issue(1, RD, 0, 0, 'hA);
    goto(tr3 + 7);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("post-reset dq_valid",  32'(dq_valid1),  32'h0);
    check("post-reset dqout",     32'(dqout1),     32'h0);
    check("post-reset busy",      32'(busy1),      32'h0);
    check("post-reset bank_open", 32'(bank_open1), 32'h0);

    // Earlier write survives the reset
    t5 = cyc;
    issue(1, ACT, 0, 0, 'h21);
    goto(t5 + 3);
    exp_beats(1, cyc + TCL1, 8, 32'h45678123, 1'b1);
    issue(1, RD, 0, 0, 0);
    goto(t5 + 16);

    // Second build: BL=4, TCL=1, 4-beat wrap
    t = cyc;
    issue(2, ACT, 3, 3, 7);
    goto(t + 3);
    check("dut2 bank_open", 32'(bank_open2), 32'h8000);
    sched_wr(cyc + TCWL, 4, 32'h12340000);
    issue(2, WR, 3, 3, 6);
    goto(t + 10);
    exp_beats(2, cyc + TCL2, 4, 32'h41230000, 1'b1);
    issue(2, RD, 3, 3, 5);
    goto(t + 15);
    exp_beats(2, cyc + TCL2, 4, 32'h34120000, 1'b1);
    issue(2, RD, 3, 3, 4);
    goto(t + 22);

    check("dut1 beats drained", 32'(rq1.size()), 32'h0);
    check("dut1 errs drained",  32'(eq1.size()), 32'h0);
    check("dut2 beats drained", 32'(rq2.size()), 32'h0);
    check("dut2 errs drained",  32'(eq2.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/dram_chip_cmd.md
Name: dram_chip_cmd

Overview:
- Parametrised successor to the per-bank-port chip model. Takes one shared DDR-style command bus (ACT/RD/WR/PRE/PREA) instead of per-bank rd/wr, row and column lanes.
- Tracks open-row state per bank and enforces tRCD, CL and CWL with counters.
- Sequences BL-beat data bursts against internal per-bank storage.
- Sits between the emulated memory controller's command/DQ interface and the chip-level storage. One instance per DRAM device in a rank.

Parameters:
- BGWIDTH, 2, bank-group address bits; BANKGROUPS = 2**BGWIDTH.
- BAWIDTH, 2, bank address bits; BANKSPERGROUP = 2**BAWIDTH.
- ADDRWIDTH, 8, modelled row address bits.
- COLWIDTH, 4, column address bits; must be >= log2(BL).
- DEVICE_WIDTH, 4, DQ bits per beat.
- BL, 8, burst length; power of two, 2..2**COLWIDTH.
- TRCD, 3, cycles from ACT to first legal RD/WR; >= 1.
- TCL, 4, cycles from RD accept to first read beat; >= 1.
- TCWL, 3, cycles from WR accept to first write beat sampled; >= 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA; 6 and 7 behave as NOP.
- bg  in  BGWIDTH  target bank group.
- ba  in  BAWIDTH  target bank within group.
- addr  in  max(ADDRWIDTH,COLWIDTH)  row for ACT; column (low COLWIDTH bits) for RD/WR.
- dqin  in  DEVICE_WIDTH  write data beat.
- dqout  out  DEVICE_WIDTH  read data beat; 0 when dq_valid is low.
- dq_valid  out  1  high on each read beat cycle.
- cmd_err  out  1  one-cycle pulse, the cycle after an illegal command.
- bank_open  out  BANKGROUPS*BANKSPERGROUP  bit (bg*BANKSPERGROUP+ba) is high when that bank is ACTIVE.
- busy  out  1  high while a burst is in flight.

Behaviour:
- Reset: all banks IDLE; timing counters cleared; burst engine idle. dqout=0, dq_valid=0, cmd_err=0, bank_open=0, busy=0. Storage contents are not reset and are undefined until written.
- Reset mid-burst: the burst is aborted. dq_valid is 0 from the cycle after reset is sampled, and no further storage writes occur.
- Per-bank FSM, states IDLE, ACTIVATING, ACTIVE:
  - IDLE --ACT--> ACTIVATING. Latch row; load counter with TRCD-1.
  - ACTIVATING moves to ACTIVE when the counter reaches 0. An ACT accepted at cycle T means the bank accepts RD/WR from cycle T+TRCD.
  - ACTIVE or ACTIVATING --PRE (this bank) or PREA--> IDLE on the next cycle.
- Illegal commands. The command is ignored, state is unchanged, and cmd_err pulses at T+1:
  - ACT to a non-IDLE bank.
  - RD/WR to a bank not ACTIVE.
  - RD/WR while busy=1.
  - PRE/PREA while busy=1 and the burst's bank is affected.
- PRE to an IDLE bank is a legal no-op.
- Burst engine (single data bus, one burst at a time):
  - RD accepted at T: busy rises at T+1. dq_valid=1 and dqout = storage[bank][row][col_i] for cycles T+TCL .. T+TCL+BL-1. busy falls after the last beat.
  - WR accepted at T: dqin is sampled and written at cycles T+TCWL .. T+TCWL+BL-1. busy falls after the last beat.
  - Beat column order: col_i = {addr[COLWIDTH-1:log2 BL], (addr[log2 BL-1:0]+i) mod BL}. This is a sequential burst that wraps within the BL-aligned block.
- A new RD/WR is legal on the cycle after busy falls. ACT/PRE to other banks is legal during a burst.
- Row and bank are latched at command accept, so a PRE after the burst cannot corrupt it.
- Storage: one array per bank, 2**(ADDRWIDTH+COLWIDTH) entries × DEVICE_WIDTH. Write is synchronous. The read path is registered so that beat timing matches the TCL figures above exactly.
- Only one command is accepted per cycle, so simultaneous commands cannot occur. Out-of-range cmd codes act as NOP.

Test Plan:
- ACT bg1 ba2 row 0x15 at T; RD at T+2 -> cmd_err at T+3, bank stays ACTIVATING. RD at T+3 is accepted, and bank_open bit 6 is high from T+3.
- WR bg0 ba0 col 0x5 with beats 1..8 from T+TCWL; then RD col 0x5 -> dqout beats 1..8 exactly at RD+4..RD+11. A second RD at col 0x0 -> 4,5,6,7,8,1,2,3 (wrap check).
- RD accepted, then a second RD while busy -> cmd_err pulse, no extra beats. ACT to another bank mid-burst -> accepted, no error.
- PREA during a write burst to bank (0,0) -> cmd_err. PREA after busy falls -> bank_open=0 next cycle. ACT to the same bank at that point -> legal.
- Assert reset at beat 3 of a read burst -> dq_valid=0, dqout=0, busy=0, bank_open=0 from the next cycle. A prior write to a different column is unaffected.
- Sweep parameters BL=4 with COLWIDTH=3, and TCL=1 -> first beat at T+1. Wrap within 4-beat blocks; bank_open width = 16.
